// File: rtl/matlab_2bit.sv
// Second-order error-feedback delta-sigma modulator with a 4-level quantizer.
// Noise transfer function (1 - z^-1)^2; one Q1.15 sample in, one registered level out per clock.
module matlab_2bit #(
    parameter int W   = 16,
    parameter int DSH = 4
) (
    input  logic                CLK,
    input  logic [15:0]         reset,
    input  logic signed [W-1:0] v_12,
    input  logic signed [W-1:0] v_tmp12,
    output logic signed [W-1:0] v_lsli
);

    localparam int SW = W + 3;

    localparam logic signed [SW-1:0] S_MAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    localparam logic signed [W-1:0] TH_NEG = {2'b11, {(W-2){1'b0}}};
    localparam logic signed [W-1:0] TH_POS = {2'b01, {(W-2){1'b0}}};

    localparam logic signed [W-1:0] Q_NEG_HI = {3'b101, {(W-3){1'b0}}};
    localparam logic signed [W-1:0] Q_NEG_LO = {3'b111, {(W-3){1'b0}}};
    localparam logic signed [W-1:0] Q_POS_LO = {3'b001, {(W-3){1'b0}}};
    localparam logic signed [W-1:0] Q_POS_HI = {3'b011, {(W-3){1'b0}}};

    function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] s);
        logic signed [W-1:0] r;
        if (s > S_MAX)
            r = S_MAX[W-1:0];
        else if (s < S_MIN)
            r = S_MIN[W-1:0];
        else
            r = s[W-1:0];
        return r;
    endfunction

    // Boundaries fall into the upper level.
    function automatic logic signed [W-1:0] quant(input logic signed [W-1:0] w);
        logic signed [W-1:0] r;
        if (w < TH_NEG)
            r = Q_NEG_HI;
        else if (w < $signed({W{1'b0}}))
            r = Q_NEG_LO;
        else if (w < TH_POS)
            r = Q_POS_LO;
        else
            r = Q_POS_HI;
        return r;
    endfunction

    logic signed [W-1:0]  e1_q, e2_q, v_lsli_q;
    logic signed [W-1:0]  e1_d, e2_d, v_lsli_d;
    logic signed [W-1:0]  dith;
    logic signed [SW-1:0] s_sum;
    logic signed [W-1:0]  w_sat;
    logic signed [W-1:0]  q_lvl;
    logic                 rst;

    assign rst  = |reset;
    assign dith = v_tmp12 >>> DSH;

    always_comb begin
        s_sum = {{3{v_12[W-1]}}, v_12}
              + {{3{dith[W-1]}}, dith}
              + {{2{e1_q[W-1]}}, e1_q, 1'b0}
              - {{3{e2_q[W-1]}}, e2_q};
        w_sat    = sat_w(s_sum);
        q_lvl    = quant(w_sat);
        // |w - q| <= 0.25 after saturation, so W bits hold the error exactly.
        e1_d     = w_sat - q_lvl;
        e2_d     = e1_q;
        v_lsli_d = q_lvl;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            e1_q     <= '0;
            e2_q     <= '0;
            v_lsli_q <= '0;
        end else begin
            e1_q     <= e1_d;
            e2_q     <= e2_d;
            v_lsli_q <= v_lsli_d;
        end
    end

    assign v_lsli = v_lsli_q;

endmodule

// File: tb/tb_matlab_2bit.sv
// Scoreboard bench for matlab_2bit: stimulus queues expected levels, a monitor pops one per edge.
module tb_matlab_2bit;

    logic               CLK;
    logic [15:0]        reset;
    logic signed [15:0] v_12;
    logic signed [15:0] v_tmp12;
    logic signed [15:0] v_lsli;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          n_vec;
    int          n_miss;
    bit          done;

    matlab_2bit #(.W(16), .DSH(4)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .v_12    (v_12),
        .v_tmp12 (v_tmp12),
        .v_lsli  (v_lsli)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One edge of stimulus: drive away from the rising edge, queue what it must produce.
    task automatic step(input logic [15:0] r, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] ex, input string tag);
        @(negedge CLK);
        reset   = r;
        v_12    = a;
        v_tmp12 = d;
        exp_q.push_back(ex);
        tag_q.push_back(tag);
    endtask

    initial begin : monitor
        logic [15:0] ex;
        string       tg;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                tg = tag_q.pop_front();
                n_vec++;
                if (v_lsli !== ex) begin
                    n_miss++;
                    $display("FAIL %s: v_lsli got %h expected %h", tg, v_lsli, ex);
                end
            end
        end
    end

    initial begin : stim
        n_vec = 0;
        n_miss = 0;
        done = 1'b0;
        reset = 16'hFFFF;
        v_12 = 16'h8560;
        v_tmp12 = 16'h8560;

        // Reset and hold, then first post-reset edge saturates negative.
        step(16'hFFFF, 16'h8560, 16'h8560, 16'h0000, "rst_hold0");
        step(16'hFFFF, 16'h8560, 16'h8560, 16'h0000, "rst_hold1");
        step(16'h0000, 16'h8560, 16'h8560, 16'hA000, "post_rst_sat");

        // Zero input: period-4 pattern.
        step(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, "zero_rst");
        step(16'h0000, 16'h0000, 16'h0000, 16'h2000, "zero0");
        step(16'h0000, 16'h0000, 16'h0000, 16'hE000, "zero1");
        step(16'h0000, 16'h0000, 16'h0000, 16'hE000, "zero2");
        step(16'h0000, 16'h0000, 16'h0000, 16'h2000, "zero3");
        step(16'h0000, 16'h0000, 16'h0000, 16'h2000, "zero4");
        step(16'h0000, 16'h0000, 16'h0000, 16'hE000, "zero5");
        // Mid-run reset on a single bit clears the error history.
        step(16'h0001, 16'h0000, 16'h0000, 16'h0000, "mid_rst");
        step(16'h0000, 16'h0000, 16'h0000, 16'h2000, "restart0");
        step(16'h0000, 16'h0000, 16'h0000, 16'hE000, "restart1");
        step(16'h0000, 16'h0000, 16'h0000, 16'hE000, "restart2");
        step(16'h0000, 16'h0000, 16'h0000, 16'h2000, "restart3");

        // Constant full level.
        step(16'h8000, 16'h6000, 16'h0000, 16'h0000, "full_rst");
        for (int i = 0; i < 4; i++)
            step(16'h0000, 16'h6000, 16'h0000, 16'h6000, "full_lvl");

        // Saturation in both directions, no wrap.
        step(16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h0000, "psat_rst");
        for (int i = 0; i < 5; i++)
            step(16'h0000, 16'h7FFF, 16'h7FFF, 16'h6000, "pos_sat");
        step(16'hFFFF, 16'h8000, 16'h8000, 16'h0000, "nsat_rst");
        for (int i = 0; i < 5; i++)
            step(16'h0000, 16'h8000, 16'h8000, 16'hA000, "neg_sat");

        // Threshold edges from the reset state.
        step(16'hFFFF, 16'h4000, 16'h0000, 16'h0000, "th_rst_a");
        step(16'h0000, 16'h4000, 16'h0000, 16'h6000, "th_4000");
        step(16'hFFFF, 16'h3FFF, 16'h0000, 16'h0000, "th_rst_b");
        step(16'h0000, 16'h3FFF, 16'h0000, 16'h2000, "th_3fff");
        step(16'hFFFF, 16'hC000, 16'h0000, 16'h0000, "th_rst_c");
        step(16'h0000, 16'hC000, 16'h0000, 16'hE000, "th_c000");
        step(16'hFFFF, 16'hBFFF, 16'h0000, 16'h0000, "th_rst_d");
        step(16'h0000, 16'hBFFF, 16'h0000, 16'hA000, "th_bfff");

        // Dither only: 0x4000 >>> 4 = 0x0400 -> +0.25 level.
        step(16'hFFFF, 16'h0000, 16'h4000, 16'h0000, "dith_rst");
        step(16'h0000, 16'h0000, 16'h4000, 16'h2000, "dith_only");

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge CLK);
        @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #100000;
        if (!done) begin
            $display("FAIL watchdog: bench still running at time %0t, required finish", $time);
            $fatal(1, "timeout");
        end
    end

endmodule
